// File: rtl/bp_dma_flit_collector.sv
// Purpose: rebuilds one wormhole packet (header + up to max_payload_flits_p flits) into a wide parallel packet.
// Latency: pkt_v_o rises the cycle after the last flit is accepted (the header itself for len=0); all outputs registered.
// Backpressure: link is stalled only while a packet is presented, until pkt_yumi_i; oversize packets are drained and dropped.
module bp_dma_flit_collector #(
   parameter int flit_width_p        = 64,
   parameter int cord_width_p        = 7,
   parameter int len_width_p         = 4,
   parameter int max_payload_flits_p = 8
) (
   input  logic                                        dma_clk_i,
   input  logic                                        dma_reset_n_i,
   input  logic [flit_width_p-1:0]                     link_data_i,
   input  logic                                        link_v_i,
   output logic                                        link_ready_and_o,
   output logic [flit_width_p-1:0]                     pkt_header_o,
   output logic [max_payload_flits_p*flit_width_p-1:0] pkt_data_o,
   output logic [len_width_p-1:0]                      pkt_len_o,
   output logic                                        pkt_v_o,
   input  logic                                        pkt_yumi_i,
   output logic                                        err_o,
   output logic [7:0]                                  err_cnt_o
);

   typedef enum logic [1:0] {
      e_idle    = 2'd0,
      e_payload = 2'd1,
      e_drain   = 2'd2,
      e_out     = 2'd3
   } state_e;

   localparam logic [len_width_p-1:0] MAX_LEN = len_width_p'(max_payload_flits_p);
   localparam logic [len_width_p-1:0] ONE_LEN = len_width_p'(1);

   state_e                                      r_state;
   state_e                                      w_state_nxt;
   logic [len_width_p-1:0]                      r_cnt;
   logic [len_width_p-1:0]                      r_len;
   logic [flit_width_p-1:0]                     r_hdr;
   logic [max_payload_flits_p*flit_width_p-1:0] r_data;
   logic                                        r_rdy;
   logic                                        r_pkt_v;
   logic                                        r_err;
   logic [7:0]                                  r_err_cnt;

   logic                                        w_accept;
   logic                                        w_last;
   logic [len_width_p-1:0]                      w_hdr_len;

   assign w_hdr_len = link_data_i[cord_width_p+len_width_p-1:cord_width_p];

   // Next-state decode: flit accept, last-flit detect and packet routing by header length.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = link_v_i & r_rdy;
      w_last      = (r_cnt == (r_len - ONE_LEN));
      case (r_state)
         e_idle: begin
            if (w_accept) begin
               if (w_hdr_len == '0)
                  w_state_nxt = e_out;
               else if (w_hdr_len <= MAX_LEN)
                  w_state_nxt = e_payload;
               else
                  w_state_nxt = e_drain;
            end
         end
         e_payload: begin
            if (w_accept && w_last)
               w_state_nxt = e_out;
         end
         e_drain: begin
            if (w_accept && w_last)
               w_state_nxt = e_idle;
         end
         e_out: begin
            if (pkt_yumi_i)
               w_state_nxt = e_idle;
         end
         default: w_state_nxt = e_idle;
      endcase
   end

   // State register plus registered ready/valid so both are low during reset.
   always_ff @(posedge dma_clk_i) begin
      if (!dma_reset_n_i) begin
         r_state <= e_idle;
         r_rdy   <= 1'b0;
         r_pkt_v <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_rdy   <= (w_state_nxt != e_out);
         r_pkt_v <= (w_state_nxt == e_out);
      end
   end

   // Header capture, flit counter and payload slot writes.
   always_ff @(posedge dma_clk_i) begin
      if (!dma_reset_n_i) begin
         r_cnt  <= '0;
         r_len  <= '0;
         r_hdr  <= '0;
         r_data <= '0;
      end else if (w_accept) begin
         if (r_state == e_idle) begin
            r_hdr <= link_data_i;
            r_len <= w_hdr_len;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + ONE_LEN;
            if (r_state == e_payload) begin
               for (int k = 0; k < max_payload_flits_p; k++) begin
                  if (r_cnt == len_width_p'(k))
                     r_data[k*flit_width_p +: flit_width_p] <= link_data_i;
               end
            end
         end
      end
   end

   // Error pulse and saturating drop counter for drained oversize packets.
   always_ff @(posedge dma_clk_i) begin
      if (!dma_reset_n_i) begin
         r_err     <= 1'b0;
         r_err_cnt <= 8'd0;
      end else begin
         r_err <= 1'b0;
         if (r_state == e_drain && w_accept && w_last) begin
            r_err <= 1'b1;
            if (r_err_cnt != 8'hFF)
               r_err_cnt <= r_err_cnt + 8'd1;
         end
      end
   end

   assign link_ready_and_o = r_rdy;
   assign pkt_v_o          = r_pkt_v;
   assign pkt_header_o     = r_hdr;
   assign pkt_data_o       = r_data;
   assign pkt_len_o        = r_len;
   assign err_o            = r_err;
   assign err_cnt_o        = r_err_cnt;

endmodule

// File: tb/tb_bp_dma_flit_collector.sv
// Directed bench for bp_dma_flit_collector with hand-computed expectations.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Counts comparisons and failures and prints one summary line.
module tb_bp_dma_flit_collector;

   localparam int W   = 64;
   localparam int MAX = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [W-1:0]     link_data;
   logic             link_v;
   logic             link_rdy;
   logic [W-1:0]     pkt_header;
   logic [MAX*W-1:0] pkt_data;
   logic [3:0]       pkt_len;
   logic             pkt_v;
   logic             pkt_yumi;
   logic             err;
   logic [7:0]       err_cnt;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   bp_dma_flit_collector #(
      .flit_width_p(W), .cord_width_p(7), .len_width_p(4), .max_payload_flits_p(MAX)
   ) dut (
      .dma_clk_i(clk), .dma_reset_n_i(rst_n),
      .link_data_i(link_data), .link_v_i(link_v), .link_ready_and_o(link_rdy),
      .pkt_header_o(pkt_header), .pkt_data_o(pkt_data), .pkt_len_o(pkt_len),
      .pkt_v_o(pkt_v), .pkt_yumi_i(pkt_yumi), .err_o(err), .err_cnt_o(err_cnt)
   );

   // Consumer protocol: yumi only while a packet is presented.
   always @(posedge clk) begin
      if (rst_n === 1'b1 && pkt_yumi === 1'b1 && pkt_v !== 1'b1) begin
         failed++;
         $error("FAIL yumi_without_valid obs=pkt_v %b exp=1", pkt_v);
      end
   end

   task automatic chk(input string tag, input logic [MAX*W-1:0] obs, input logic [MAX*W-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] mkhdr(input logic [52:0] upper, input logic [3:0] len, input logic [6:0] cord);
      return {upper, len, cord};
   endfunction

   task automatic send(input logic [W-1:0] d);
      link_v    = 1'b1;
      link_data = d;
      tick();
      link_v    = 1'b0;
   endtask

   initial begin
      logic [W-1:0]     h;
      logic [MAX*W-1:0] exp_data;
      logic [W-1:0]     hold_hdr;
      logic [MAX*W-1:0] hold_data;
      int               err_seen;

      rst_n = 1'b0; link_v = 1'b0; link_data = '0; pkt_yumi = 1'b0;
      tick(); tick();
      chk("rst_ready",  link_rdy,   0);
      chk("rst_pkt_v",  pkt_v,      0);
      chk("rst_err",    err,        0);
      chk("rst_errcnt", err_cnt,    0);
      chk("rst_len",    pkt_len,    0);
      chk("rst_hdr",    pkt_header, 0);
      chk("rst_data",   pkt_data,   0);
      rst_n = 1'b1;
      tick();
      chk("rel_ready", link_rdy, 1);

      // len=0, cord=5
      h = mkhdr(53'h1ABCD, 4'd0, 7'd5);
      send(h);
      chk("l0_pkt_v", pkt_v, 1);
      chk("l0_len",   pkt_len, 0);
      chk("l0_hdr",   pkt_header, h);
      chk("l0_ready", link_rdy, 0);
      pkt_yumi = 1'b1; tick(); pkt_yumi = 1'b0;
      chk("l0_ready_after_yumi", link_rdy, 1);
      chk("l0_v_after_yumi",     pkt_v, 0);

      // len=3 back-to-back, then held for 10 cycles with link_v asserted
      h = mkhdr(53'h33, 4'd3, 7'd9);
      send(h);
      send(64'hAAAA_0000_0000_0001);
      send(64'hBBBB_0000_0000_0002);
      chk("l3_v_before_last", pkt_v, 0);
      send(64'hCCCC_0000_0000_0003);
      chk("l3_pkt_v", pkt_v, 1);
      chk("l3_len",   pkt_len, 3);
      chk("l3_hdr",   pkt_header, h);
      chk("l3_slot0", pkt_data[0*W +: W], 64'hAAAA_0000_0000_0001);
      chk("l3_slot1", pkt_data[1*W +: W], 64'hBBBB_0000_0000_0002);
      chk("l3_slot2", pkt_data[2*W +: W], 64'hCCCC_0000_0000_0003);
      hold_hdr  = h;
      hold_data = pkt_data;
      link_v = 1'b1; link_data = 64'hDEAD_BEEF_DEAD_BEEF;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("l3_hold_ready", link_rdy, 0);
         chk("l3_hold_v",     pkt_v, 1);
         chk("l3_hold_hdr",   pkt_header, hold_hdr);
         chk("l3_hold_data",  pkt_data, hold_data);
         chk("l3_hold_len",   pkt_len, 3);
      end
      link_v = 1'b0;
      pkt_yumi = 1'b1; tick(); pkt_yumi = 1'b0;
      chk("l3_ready_after_yumi", link_rdy, 1);

      // len=8 with random bubbles
      h = mkhdr(53'h88, 4'd8, 7'd1);
      send(h);
      exp_data = '0;
      for (int k = 0; k < MAX; k++) begin
         if ($urandom_range(0, 1) == 1) begin
            tick();
            chk("l8_bubble_v", pkt_v, 0);
         end
         exp_data[k*W +: W] = 64'h8000_0000_0000_0000 | 64'(k * 17 + 3);
         send(exp_data[k*W +: W]);
         if (k < MAX - 1) chk("l8_v_early", pkt_v, 0);
      end
      chk("l8_pkt_v", pkt_v, 1);
      chk("l8_len",   pkt_len, 8);
      chk("l8_data",  pkt_data, exp_data);
      chk("l8_hdr",   pkt_header, h);
      pkt_yumi = 1'b1; tick(); pkt_yumi = 1'b0;

      // len=12 oversize: drained, error pulse, then len=1 delivered
      send(mkhdr(53'hC, 4'd12, 7'd2));
      err_seen = 0;
      for (int k = 0; k < 12; k++) begin
         chk("l12_err_low", err, 0);
         send(64'h1200 + 64'(k));
         chk("l12_v_low", pkt_v, 0);
      end
      chk("l12_err_pulse", err, 1);
      chk("l12_errcnt",    err_cnt, 1);
      chk("l12_ready",     link_rdy, 1);
      h = mkhdr(53'h11, 4'd1, 7'd3);
      send(h);
      chk("l12_err_one_cycle", err, 0);
      send(64'h0123_4567_89AB_CDEF);
      chk("l1_pkt_v", pkt_v, 1);
      chk("l1_len",   pkt_len, 1);
      chk("l1_hdr",   pkt_header, h);
      chk("l1_slot0", pkt_data[0 +: W], 64'h0123_4567_89AB_CDEF);
      chk("l1_errcnt", err_cnt, 1);
      pkt_yumi = 1'b1; tick(); pkt_yumi = 1'b0;

      // 256 more oversize packets (len=9): counter saturates at 255
      for (int p = 0; p < 256; p++) begin
         send(mkhdr(53'h9, 4'd9, 7'd4));
         for (int k = 0; k < 9; k++) send(64'(k));
         if (err === 1'b1) err_seen++;
         if (p == 253) chk("sat_reach", err_cnt, 255);
      end
      chk("sat_hold",   err_cnt, 255);
      chk("sat_pulses", err_seen, 256);
      chk("sat_v_low",  pkt_v, 0);

      // Reset after the 2nd payload flit of a len=4 packet
      send(mkhdr(53'h44, 4'd4, 7'd6));
      send(64'h4401);
      send(64'h4402);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_ready",  link_rdy, 0);
      chk("mid_rst_v",      pkt_v, 0);
      chk("mid_rst_err",    err, 0);
      chk("mid_rst_errcnt", err_cnt, 0);
      rst_n = 1'b1;
      tick();
      chk("mid_rel_ready", link_rdy, 1);
      h = mkhdr(53'h77, 4'd1, 7'd7);
      send(h);
      chk("new_err0", err, 0);
      chk("new_v0",   pkt_v, 0);
      send(64'h7777_0000_0000_0001);
      chk("new_pkt_v",  pkt_v, 1);
      chk("new_hdr",    pkt_header, h);
      chk("new_len",    pkt_len, 1);
      chk("new_slot0",  pkt_data[0 +: W], 64'h7777_0000_0000_0001);
      chk("new_err1",   err, 0);
      chk("new_errcnt", err_cnt, 0);
      pkt_yumi = 1'b1; tick(); pkt_yumi = 1'b0;
      chk("new_done_v", pkt_v, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
